// File: rtl/snn_ctrl_pkg.sv
// Shared types and helpers for the SNN inference sequencer.
package snn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } ctrl_state_e;

    localparam int UNDERRUN_W = 16;

    function automatic int cls_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// Input-spike word buffer; head is combinational and reads zero when empty.
module spike_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Window sequencer for the SNN core: feeds buffered spike words, counts output spikes, reports argmax.
// Build option SNN_CTRL_SAT_STATS_EN: saturating spike counters plus an underrun_cnt output.
//
//   state  | meaning
//   IDLE   | waiting for core ready and a buffered word
//   RUN    | window in progress, net_start held, samples and spikes counted
//   REPORT | result held on res_* until consumer accepts
module snn_inference_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int WINDOW     = 6,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN-1:0]          in_data,
    input  logic                     net_ready,
    output logic                     net_start,
    output logic                     net_sample_ready,
    input  logic                     net_sample,
    output logic [N_IN-1:0]          net_in_spikes,
    input  logic [N_OUT-1:0]         net_out_spikes,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [cls_w(N_OUT)-1:0]  res_class,
    output logic [N_OUT*CNT_W-1:0]   res_counts,
    output logic                     busy
`ifdef SNN_CTRL_SAT_STATS_EN
    ,
    output logic [UNDERRUN_W-1:0]    underrun_cnt
`endif
);

    localparam int CLS_W  = cls_w(N_OUT);
    localparam int SAMP_W = $clog2(WINDOW + 1);

    ctrl_state_e            r_state;
    ctrl_state_e            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt [N_OUT];
    logic [CNT_W-1:0]       w_cnt_nxt [N_OUT];
    logic [SAMP_W-1:0]      r_samp_cnt;
    logic [N_OUT*CNT_W-1:0] r_res_counts;
    logic [CLS_W-1:0]       r_res_class;
    logic [CLS_W-1:0]       w_best_idx;
    logic [CNT_W-1:0]       w_best_cnt;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_window_done;
    logic                   w_res_fire;

    assign w_push        = in_valid && !w_full;
    assign w_pop         = (r_state == RUN) && net_sample && !w_empty;
    assign w_window_done = w_pop && (r_samp_cnt == SAMP_W'(WINDOW - 1));
    assign w_res_fire    = (r_state == REPORT) && res_ready;

    assign in_ready   = !w_full;
    assign busy       = (r_state != IDLE);
    assign res_counts = r_res_counts;
    assign res_class  = r_res_class;

    spike_fifo #(
        .WIDTH (N_IN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_data),
        .full  (w_full),
        .empty (w_empty),
        .head  (net_in_spikes)
    );

    always_comb begin
        w_state_nxt      = r_state;
        net_start        = 1'b0;
        net_sample_ready = 1'b0;
        res_valid        = 1'b0;
        case (r_state)
            IDLE: begin
                if (net_ready && !w_empty) w_state_nxt = RUN;
            end
            RUN: begin
                net_start        = 1'b1;
                net_sample_ready = !w_empty;
                if (w_window_done) w_state_nxt = REPORT;
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Spikes only count while RUN, so the final-sample cycle is included in the latched result.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if ((r_state == RUN) && net_out_spikes[i]) begin
`ifdef SNN_CTRL_SAT_STATS_EN
                if (r_cnt[i] != '1) w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
`else
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
`endif
            end
        end
    end

    always_comb begin
        w_best_idx = '0;
        w_best_cnt = w_cnt_nxt[0];
        for (int i = 1; i < N_OUT; i++) begin
            if (w_cnt_nxt[i] > w_best_cnt) begin
                w_best_cnt = w_cnt_nxt[i];
                w_best_idx = CLS_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_samp_cnt   <= '0;
            r_res_counts <= '0;
            r_res_class  <= '0;
            for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_res_fire) begin
                r_samp_cnt <= '0;
                for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
            end else begin
                for (int i = 0; i < N_OUT; i++) r_cnt[i] <= w_cnt_nxt[i];
                if (w_pop) r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
            end
            if (w_window_done) begin
                r_res_class <= w_best_idx;
                for (int i = 0; i < N_OUT; i++) r_res_counts[i*CNT_W +: CNT_W] <= w_cnt_nxt[i];
            end
        end
    end

`ifdef SNN_CTRL_SAT_STATS_EN
    logic                  w_underrun;
    logic [UNDERRUN_W-1:0] r_underrun_cnt;

    assign w_underrun   = (r_state == RUN) && net_sample && w_empty;
    assign underrun_cnt = r_underrun_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun && (r_underrun_cnt != '1)) begin
            r_underrun_cnt <= r_underrun_cnt + UNDERRUN_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Self-checking bench for snn_inference_ctrl: directed window sequences plus randomized traffic vs a queue model.
`timescale 1ns/1ps
module tb_snn_inference_ctrl;
    import snn_ctrl_pkg::*;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int DEPTH = 8;
    localparam int WIN   = 6;
    localparam int CW    = 8;
    localparam int CLSW  = cls_w(N_OUT);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [N_IN-1:0] in_data = '0;
    logic net_ready = 1'b0;
    logic net_sample = 1'b0;
    logic [N_OUT-1:0] spk = '0;
    logic res_ready = 1'b0;
    logic in_ready, net_start, net_sample_ready, res_valid, busy;
    logic [N_IN-1:0] net_in_spikes;
    logic [CLSW-1:0] res_class;
    logic [N_OUT*CW-1:0] res_counts;
`ifdef SNN_CTRL_SAT_STATS_EN
    logic [UNDERRUN_W-1:0] underrun_cnt;
`endif

    always #5 clk = ~clk;

    snn_inference_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .FIFO_DEPTH(DEPTH), .WINDOW(WIN), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .net_ready(net_ready), .net_start(net_start), .net_sample_ready(net_sample_ready),
        .net_sample(net_sample), .net_in_spikes(net_in_spikes), .net_out_spikes(spk),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_counts(res_counts), .busy(busy)
`ifdef SNN_CTRL_SAT_STATS_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    // Reference model: mode 0 waiting, 1 collecting a window, 2 holding a result.
    logic [N_IN-1:0] mq[$];
    int m_cnt[N_OUT];
    int m_res[N_OUT];
    int m_samp, m_mode, m_cls, m_under;
    int cmp_n = 0;
    int err_n = 0;

    typedef struct {
        logic            v;
        logic [N_IN-1:0] d;
        logic            exp_rdy;
        logic [N_IN-1:0] exp_head;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bump(input int c);
`ifdef SNN_CTRL_SAT_STATS_EN
        return (c < (1 << CW) - 1) ? c + 1 : c;
`else
        return (c + 1) % (1 << CW);
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < N_OUT; i++) begin
            m_cnt[i] = 0;
            m_res[i] = 0;
        end
        m_samp = 0; m_mode = 0; m_cls = 0; m_under = 0;
    endtask

    task automatic model_step();
        int sz;
        bit push, accept;
        sz = mq.size();
        push = in_valid && (sz < DEPTH);
        accept = 0;
        case (m_mode)
            0: if (net_ready && sz > 0) m_mode = 1;
            1: begin
                for (int i = 0; i < N_OUT; i++) if (spk[i]) m_cnt[i] = bump(m_cnt[i]);
                if (net_sample) begin
                    if (sz > 0) accept = 1;
                    else if (m_under < 65535) m_under++;
                end
                if (accept) begin
                    m_samp++;
                    if (m_samp == WIN) begin
                        m_cls = 0;
                        for (int i = 0; i < N_OUT; i++) begin
                            m_res[i] = m_cnt[i];
                            if (m_cnt[i] > m_cnt[m_cls]) m_cls = i;
                        end
                        m_mode = 2;
                    end
                end
            end
            default: if (res_ready) begin
                for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
                m_samp = 0;
                m_mode = 0;
            end
        endcase
        if (accept) void'(mq.pop_front());
        if (push) mq.push_back(in_data);
    endtask

    // Called at posedge+1 with inputs set; compares on the falling edge, then advances the model.
    task automatic cycle();
        @(negedge clk);
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("net_start", net_start, m_mode == 1);
        chk("net_sample_ready", net_sample_ready, (m_mode == 1) && (mq.size() > 0));
        chk("net_in_spikes", net_in_spikes, (mq.size() > 0) ? mq[0] : '0);
        chk("res_valid", res_valid, m_mode == 2);
        chk("busy", busy, m_mode != 0);
        for (int i = 0; i < N_OUT; i++) chk("res_counts", res_counts[i*CW +: CW], m_res[i]);
        chk("res_class", res_class, m_cls);
`ifdef SNN_CTRL_SAT_STATS_EN
        chk("underrun_cnt", underrun_cnt, m_under);
`endif
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [N_IN-1:0] w);
        in_valid = 1'b1; in_data = w;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic kick();
        net_ready = 1'b1;
        cycle();
        net_ready = 1'b0;
    endtask

    task automatic pulses(input int n, input int gap);
        for (int p = 0; p < n; p++) begin
            net_sample = 1'b1;
            cycle();
            net_sample = 1'b0;
            repeat (gap) cycle();
        end
    endtask

    task automatic ack();
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
    endtask

    logic [N_IN-1:0] seq1 [6];
    int pcount;

    initial begin
        for (int k = 0; k < 10; k++) begin
            tbl[k].v        = (k < 9);
            tbl[k].d        = N_IN'(k + 1);
            tbl[k].exp_rdy  = (k < 8);
            tbl[k].exp_head = (k == 0) ? '0 : N_IN'(1);
        end
        seq1[0] = 4'hF; seq1[1] = 4'hE; seq1[2] = 4'hD;
        seq1[3] = 4'hC; seq1[4] = 4'hF; seq1[5] = 4'hF;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_net_start", net_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_counts", res_counts, 0);
        rst_n = 1'b1;
        cycle();

        // Window 1: F,E,D,C,F,F sampled every 10 cycles; spikes 01 x3 then 10 x5
        for (int k = 0; k < 6; k++) push_word(seq1[k]);
        kick();
        pcount = 0;
        for (int k = 0; k < 60; k++) begin
            net_sample = (k % 10 == 9);
            spk = (k < 3) ? 2'b01 : (k < 8) ? 2'b10 : 2'b00;
            if (net_sample) begin
                chk("head_order", net_in_spikes, seq1[pcount]);
                pcount++;
            end
            cycle();
        end
        net_sample = 1'b0; spk = '0;
        chk("res_latency", res_valid, 1);
        chk("res_cnt0", res_counts[7:0], 3);
        chk("res_cnt1", res_counts[15:8], 5);
        chk("res_class_1", res_class, 1);
        chk("fifo_drained", net_in_spikes, 0);
        repeat (20) cycle();
        chk("hold_valid", res_valid, 1);
        chk("hold_counts", res_counts, 16'h0503);
        ack();
        chk("after_ack_busy", busy, 0);

        // Window 2: tie 4/4 -> lowest index
        for (int k = 0; k < 6; k++) push_word(N_IN'(k + 3));
        kick();
        for (int k = 0; k < 18; k++) begin
            spk = (k < 4) ? 2'b11 : 2'b00;
            net_sample = (k % 3 == 2);
            cycle();
        end
        spk = '0; net_sample = 1'b0;
        chk("tie_counts", res_counts, 16'h0404);
        chk("tie_class", res_class, 0);
        ack();

        // Fill past capacity with the core not ready
        for (int k = 0; k < 10; k++) begin
            in_valid = tbl[k].v;
            in_data  = tbl[k].d;
            chk("fill_in_ready", in_ready, tbl[k].exp_rdy);
            chk("fill_head", net_in_spikes, tbl[k].exp_head);
            cycle();
        end
        in_valid = 1'b0;
        kick();
        pulses(6, 1);
        ack();
        chk("leftover_head", net_in_spikes, 7);

        // Underrun: drain mid-window, ignored pulses must not advance the window
        kick();
        pulses(2, 1);
        chk("underrun_sready", net_sample_ready, 0);
        pulses(2, 1);
        for (int k = 0; k < 4; k++) push_word(N_IN'(k + 10));
        pulses(3, 1);
        chk("underrun_no_early", res_valid, 0);
        pulses(1, 0);
        chk("underrun_done", res_valid, 1);
`ifdef SNN_CTRL_SAT_STATS_EN
        chk("underrun_cnt_2", underrun_cnt, 2);
`endif
        ack();

        // 300 spikes on neuron 0 in one window
        for (int k = 0; k < 6; k++) push_word(4'h5);
        kick();
        spk = 2'b01;
        repeat (300) cycle();
        spk = '0;
        pulses(6, 1);
`ifdef SNN_CTRL_SAT_STATS_EN
        chk("big_cnt0", res_counts[7:0], 255);
`else
        chk("big_cnt0", res_counts[7:0], 44);
`endif
        chk("big_class", res_class, 0);
        ack();

        // Reset mid-window
        for (int k = 0; k < 3; k++) push_word(4'h9);
        kick();
        pulses(1, 1);
        spk = 2'b10;
        cycle();
        spk = '0;
        rst_n = 1'b0;
        #2;
        chk("midrst_start", net_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_head", net_in_spikes, 0);
        chk("midrst_res_valid", res_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        for (int k = 0; k < 6; k++) push_word(4'hA);
        kick();
        spk = 2'b10;
        cycle();
        spk = '0;
        pulses(6, 0);
        chk("post_rst_valid", res_valid, 1);
        chk("post_rst_counts", res_counts, 16'h0100);
        chk("post_rst_class", res_class, 1);
        ack();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            in_valid   = ($urandom_range(0, 1) == 1);
            in_data    = N_IN'($urandom);
            net_ready  = ($urandom_range(0, 3) != 0);
            net_sample = ($urandom_range(0, 3) == 0);
            spk        = N_OUT'($urandom);
            res_ready  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
